// File: rtl/dectape_pkg.sv
// Shared DECtape definitions: mark codes, framing constants and the
// line-reader state encoding. Also used by the TC08 control and writer blocks.
package dectape_pkg;

  localparam int unsigned LINE_W     = 3;
  localparam int unsigned MARK_W     = 6;
  localparam int unsigned WORD_W     = 18;
  localparam int unsigned WORD_LINES = 6;

  localparam logic [MARK_W-1:0] MK_END   = 6'o22;
  localparam logic [MARK_W-1:0] MK_BLOCK = 6'o26;
  localparam logic [MARK_W-1:0] MK_GUARD = 6'o32;
  localparam logic [MARK_W-1:0] MK_LOCK  = 6'o10;
  localparam logic [MARK_W-1:0] MK_DATA  = 6'o70;
  localparam logic [MARK_W-1:0] MK_FINAL = 6'o73;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // True when a six-line mark window holds one of the recognised codes.
  function automatic logic is_legal_mark(input logic [MARK_W-1:0] win);
    case (win)
      MK_END, MK_BLOCK, MK_GUARD, MK_LOCK, MK_DATA, MK_FINAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dectape_diff_sync.sv
// Synchronizer for one differential read-head pair.
//   clk, rst  : clock, synchronous active-high reset
//   rev       : 1 = complement the bit value (reverse tape motion)
//   pos, neg  : raw head pair
//   valid_c   : synchronized pair is differential (pos ^ neg)
//   value_c   : synchronized pos, complemented when rev = 1
module dectape_diff_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rev,
  input  logic pos,
  input  logic neg,
  output logic valid_c,
  output logic value_c
);

  logic [SYNC_STAGES-1:0] pos_q;
  logic [SYNC_STAGES-1:0] neg_q;

  // Plain flop chain per leg; the last stage is the usable sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      pos_q[0] <= pos;
      neg_q[0] <= neg;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        pos_q[i] <= pos_q[i-1];
        neg_q[i] <= neg_q[i-1];
      end
    end
  end

  assign valid_c = pos_q[SYNC_STAGES-1] ^ neg_q[SYNC_STAGES-1];
  assign value_c = pos_q[SYNC_STAGES-1] ^ rev;

endmodule

// File: rtl/dectape_line_reader.sv
// TU55 read front end: turns the five read-head pairs into line strobes,
// mark-track framing and assembled 18-bit words.
//   clk, rst        : clock, synchronous active-high reset
//   rev             : tape direction, 1 = reverse
//   *_rd_pos/_neg   : timing, mark and three data head pairs
//   line_stb        : one pulse per tape line; line_data/line_mark hold its bits
//   moving          : timing track active (no timeout since the last strobe)
//   locked          : word framing established
//   word_valid      : pulse with word_data/word_mark at each word boundary
//   block_mark      : pulse with a word whose mark window is MK_BLOCK
//   mark_err        : pulse when a locked boundary holds an illegal mark
module dectape_line_reader
  import dectape_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rev,
  input  logic              t_trk_rd_pos,
  input  logic              t_trk_rd_neg,
  input  logic              rdmk_rd_pos,
  input  logic              rdmk_rd_neg,
  input  logic              rdd_00_rd_pos,
  input  logic              rdd_00_rd_neg,
  input  logic              rdd_01_rd_pos,
  input  logic              rdd_01_rd_neg,
  input  logic              rdd_02_rd_pos,
  input  logic              rdd_02_rd_neg,
  output logic              line_stb,
  output logic [LINE_W-1:0] line_data,
  output logic              line_mark,
  output logic              moving,
  output logic              locked,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [MARK_W-1:0] word_mark,
  output logic              block_mark,
  output logic              mark_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LC_W  = 3;

  logic t_valid_c, t_value_c;
  logic mk_valid_c, mk_value_c;
  logic d0_valid_c, d0_value_c;
  logic d1_valid_c, d1_value_c;
  logic d2_valid_c, d2_value_c;

  // Timing pair is edge-detected on the raw pos leg, so it never gets the rev complement.
  dectape_diff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_t (
    .clk(clk), .rst(rst), .rev(1'b0), .pos(t_trk_rd_pos), .neg(t_trk_rd_neg),
    .valid_c(t_valid_c), .value_c(t_value_c));
  dectape_diff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mk (
    .clk(clk), .rst(rst), .rev(rev), .pos(rdmk_rd_pos), .neg(rdmk_rd_neg),
    .valid_c(mk_valid_c), .value_c(mk_value_c));
  dectape_diff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d0 (
    .clk(clk), .rst(rst), .rev(rev), .pos(rdd_00_rd_pos), .neg(rdd_00_rd_neg),
    .valid_c(d0_valid_c), .value_c(d0_value_c));
  dectape_diff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d1 (
    .clk(clk), .rst(rst), .rev(rev), .pos(rdd_01_rd_pos), .neg(rdd_01_rd_neg),
    .valid_c(d1_valid_c), .value_c(d1_value_c));
  dectape_diff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d2 (
    .clk(clk), .rst(rst), .rev(rev), .pos(rdd_02_rd_pos), .neg(rdd_02_rd_neg),
    .valid_c(d2_valid_c), .value_c(d2_value_c));

  state_t            state;
  logic [LC_W-1:0]   lc;
  logic [MARK_W-1:0] win;
  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              t_prev;
  logic              rev_q;

  logic              edge_c;
  logic              rev_chg_c;
  logic              tmo_c;
  logic              mark_c;
  logic [LINE_W-1:0] data_c;
  logic [MARK_W-1:0] win_nx_c;
  logic [WORD_W-1:0] sr_nx_c;

  // Strobe/timeout detection and the next window/shift contents for this line.
  always_comb begin
    edge_c    = t_valid_c & t_value_c & ~t_prev;
    rev_chg_c = rev ^ rev_q;
    // Fires on the cycle the counter steps onto TIMEOUT_CYCLES, so moving
    // drops exactly TIMEOUT_CYCLES cycles after the line_stb pulse.
    tmo_c     = ~edge_c & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    mark_c    = mk_valid_c & mk_value_c;
    data_c    = {d0_valid_c & d0_value_c, d1_valid_c & d1_value_c, d2_valid_c & d2_value_c};
    // In reverse the lines arrive last-first; filling from the top keeps each
    // line's {d00,d01,d02} triad and the mark bits in written order.
    if (rev) begin
      win_nx_c = {mark_c, win[MARK_W-1:1]};
      sr_nx_c  = {data_c, sr[WORD_W-1:LINE_W]};
    end else begin
      win_nx_c = {win[MARK_W-2:0], mark_c};
      sr_nx_c  = {sr[WORD_W-LINE_W-1:0], data_c};
    end
  end

  // Line capture, motion timer and framing state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lc         <= '0;
      win        <= '0;
      sr         <= '0;
      cnt        <= '0;
      t_prev     <= 1'b0;
      rev_q      <= 1'b0;
      line_stb   <= 1'b0;
      line_data  <= '0;
      line_mark  <= 1'b0;
      moving     <= 1'b0;
      locked     <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_mark  <= '0;
      block_mark <= 1'b0;
      mark_err   <= 1'b0;
    end else begin
      t_prev     <= t_value_c;
      rev_q      <= rev;
      line_stb   <= edge_c;
      word_valid <= 1'b0;
      block_mark <= 1'b0;
      mark_err   <= 1'b0;

      if (edge_c) begin
        line_data <= data_c;
        line_mark <= mark_c;
        win       <= win_nx_c;
        sr        <= sr_nx_c;
        cnt       <= '0;
        moving    <= 1'b1;
      end else begin
        if (cnt != CNT_W'(TIMEOUT_CYCLES)) cnt <= cnt + CNT_W'(1);
        if (tmo_c) moving <= 1'b0;
      end

      if (rev_chg_c) begin
        // Window contents from the other direction are meaningless; start clean.
        win    <= '0;
        sr     <= '0;
        state  <= IDLE;
        lc     <= '0;
        locked <= 1'b0;
      end else if (edge_c) begin
        case (state)
          IDLE: begin
            state <= HUNT;
          end
          HUNT: begin
            if (is_legal_mark(win_nx_c)) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              lc         <= '0;
              word_valid <= 1'b1;
              word_data  <= sr_nx_c;
              word_mark  <= win_nx_c;
              block_mark <= (win_nx_c == MK_BLOCK);
            end
          end
          LOCKED: begin
            if (lc == LC_W'(WORD_LINES - 1)) begin
              lc <= '0;
              if (is_legal_mark(win_nx_c)) begin
                word_valid <= 1'b1;
                word_data  <= sr_nx_c;
                word_mark  <= win_nx_c;
                block_mark <= (win_nx_c == MK_BLOCK);
              end else begin
                mark_err <= 1'b1;
                state    <= HUNT;
                locked   <= 1'b0;
              end
            end else begin
              lc <= lc + LC_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            lc     <= '0;
            locked <= 1'b0;
          end
        endcase
      end else if (tmo_c) begin
        state  <= IDLE;
        lc     <= '0;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dectape_line_reader.sv
// Directed bench for dectape_line_reader: forward/reverse framing, mark
// errors, motion timeout, rev toggle and reset mid-word.
module tb_dectape_line_reader;
  import dectape_pkg::*;

  localparam int unsigned T = 10000;
  localparam logic [17:0] W_A = 18'o701234;
  localparam logic [17:0] W_B = 18'o123456;
  localparam logic [17:0] W_Z = 18'o000000;

  logic        clk;
  logic        rst;
  logic        rev;
  logic        t_pos, t_neg, mk_pos, mk_neg;
  logic        d0_pos, d0_neg, d1_pos, d1_neg, d2_pos, d2_neg;
  logic        line_stb;
  logic [2:0]  line_data;
  logic        line_mark;
  logic        moving;
  logic        locked;
  logic        word_valid;
  logic [17:0] word_data;
  logic [5:0]  word_mark;
  logic        block_mark;
  logic        mark_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_stb = 0;
  int rise_cyc = 0;
  int first_lat = -1;
  int stb_cnt = 0;
  int wv_cnt = 0;
  int bm_cnt = 0;
  int me_cnt = 0;
  logic [17:0] last_wd = '0;
  logic [5:0]  last_wm = '0;

  dectape_line_reader #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rev(rev),
    .t_trk_rd_pos(t_pos), .t_trk_rd_neg(t_neg),
    .rdmk_rd_pos(mk_pos), .rdmk_rd_neg(mk_neg),
    .rdd_00_rd_pos(d0_pos), .rdd_00_rd_neg(d0_neg),
    .rdd_01_rd_pos(d1_pos), .rdd_01_rd_neg(d1_neg),
    .rdd_02_rd_pos(d2_pos), .rdd_02_rd_neg(d2_neg),
    .line_stb(line_stb), .line_data(line_data), .line_mark(line_mark),
    .moving(moving), .locked(locked), .word_valid(word_valid),
    .word_data(word_data), .word_mark(word_mark),
    .block_mark(block_mark), .mark_err(mark_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (line_stb) begin
      stb_cnt++;
      last_stb = cyc;
      if (first_lat < 0) first_lat = cyc - rise_cyc;
    end
    if (word_valid) begin
      wv_cnt++;
      last_wd = word_data;
      last_wm = word_mark;
    end
    if (block_mark) bm_cnt++;
    if (mark_err) me_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Quiet head levels; inv models the transport's reverse inversion.
  task automatic set_idle(input logic inv);
    t_pos = inv;  t_neg = ~inv;
    mk_pos = inv; mk_neg = ~inv;
    d0_pos = inv; d0_neg = ~inv;
    d1_pos = inv; d1_neg = ~inv;
    d2_pos = inv; d2_neg = ~inv;
  endtask

  // One tape line: data settles, timing goes active, then returns.
  task automatic send_line(input logic [2:0] d, input logic m, input logic inv);
    @(negedge clk);
    d0_pos = d[2] ^ inv; d0_neg = ~d0_pos;
    d1_pos = d[1] ^ inv; d1_neg = ~d1_pos;
    d2_pos = d[0] ^ inv; d2_neg = ~d2_pos;
    mk_pos = m ^ inv;    mk_neg = ~mk_pos;
    repeat (10) @(negedge clk);
    t_pos = ~inv; t_neg = inv;
    if (!inv) rise_cyc = cyc;
    repeat (20) @(negedge clk);
    t_pos = inv; t_neg = ~inv;
    if (inv) rise_cyc = cyc;
    repeat (10) @(negedge clk);
  endtask

  // Lines first..first+n-1 of a written word (line 0 = bits 17:15, mark bit 5);
  // backwards replays them last-first as the reverse pass sees them.
  task automatic send_word(input logic [17:0] w, input logic [5:0] mk, input logic inv,
                           input logic backwards, input int first, input int n);
    logic [17:0] ws;
    logic [5:0]  ms;
    int j;
    for (int k = first; k < first + n; k++) begin
      j  = backwards ? 5 - k : k;
      ws = w << (3 * j);
      ms = mk << j;
      send_line(ws[17:15], ms[5], inv);
    end
  endtask

  initial begin
    rst = 1'b1;
    rev = 1'b0;
    t_pos = 0; t_neg = 0; mk_pos = 0; mk_neg = 0;
    d0_pos = 0; d0_neg = 0; d1_pos = 0; d1_neg = 0; d2_pos = 0; d2_neg = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_line_stb",   32'(line_stb), 0);
    chk("rst_line_data",  32'(line_data), 0);
    chk("rst_moving",     32'(moving), 0);
    chk("rst_locked",     32'(locked), 0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_word_data",  32'(word_data), 0);
    chk("rst_word_mark",  32'(word_mark), 0);
    chk("rst_pulses",     32'({block_mark, mark_err}), 0);

    // No head activity.
    set_idle(1'b0);
    repeat (20000) @(negedge clk);
    chk("idle_moving", 32'(moving), 0);
    chk("idle_locked", 32'(locked), 0);
    chk("idle_stb",    32'(stb_cnt), 0);
    chk("idle_words",  32'(wv_cnt), 0);

    // Forward: block mark word, then data word.
    send_word(W_A, 6'o26, 1'b0, 1'b0, 0, 6);
    chk("fwd_latency",   32'(first_lat), 3);
    chk("fwd_stb_count", 32'(stb_cnt), 6);
    chk("fwd_line_data", 32'(line_data), 32'o4);
    chk("fwd_line_mark", 32'(line_mark), 0);
    chk("fwd_lock",      32'(locked), 1);
    chk("fwd_moving",    32'(moving), 1);
    chk("fwd_wv_a",      32'(wv_cnt), 1);
    chk("fwd_wd_a",      32'(last_wd), 32'(W_A));
    chk("fwd_wm_a",      32'(last_wm), 32'o26);
    chk("fwd_bm_a",      32'(bm_cnt), 1);
    send_word(W_B, 6'o70, 1'b0, 1'b0, 0, 6);
    chk("fwd_wv_b",      32'(wv_cnt), 2);
    chk("fwd_wd_b",      32'(last_wd), 32'(W_B));
    chk("fwd_wm_b",      32'(last_wm), 32'o70);
    chk("fwd_bm_b",      32'(bm_cnt), 1);

    // Illegal mark at a locked boundary, then relock.
    send_word(W_Z, 6'o77, 1'b0, 1'b0, 0, 6);
    chk("err_pulse",  32'(me_cnt), 1);
    chk("err_no_wv",  32'(wv_cnt), 2);
    chk("err_locked", 32'(locked), 0);
    send_word(W_A, 6'o26, 1'b0, 1'b0, 0, 6);
    chk("relock",     32'(locked), 1);
    chk("relock_wv",  32'(wv_cnt), 3);
    chk("relock_wd",  32'(last_wd), 32'(W_A));
    chk("relock_bm",  32'(bm_cnt), 2);

    // Timing track stops mid-word.
    send_word(W_B, 6'o70, 1'b0, 1'b0, 0, 3);
    while (cyc < last_stb + int'(T) - 1) @(negedge clk);
    chk("tmo_moving_before", 32'(moving), 1);
    chk("tmo_locked_before", 32'(locked), 1);
    @(negedge clk);
    chk("tmo_moving_after", 32'(moving), 0);
    chk("tmo_locked_after", 32'(locked), 0);
    chk("tmo_no_partial",   32'(wv_cnt), 3);

    // Reverse replay of the same image with inverted heads.
    set_idle(1'b1);
    repeat (10) @(negedge clk);
    rev = 1'b1;
    repeat (5) @(negedge clk);
    chk("rev_idle_locked", 32'(locked), 0);
    send_word(W_B, 6'o70, 1'b1, 1'b1, 0, 6);
    chk("rev_wv_b",   32'(wv_cnt), 4);
    chk("rev_wd_b",   32'(last_wd), 32'(W_B));
    chk("rev_wm_b",   32'(last_wm), 32'o70);
    chk("rev_locked", 32'(locked), 1);
    send_word(W_A, 6'o26, 1'b1, 1'b1, 0, 6);
    chk("rev_wv_a",   32'(wv_cnt), 5);
    chk("rev_wd_a",   32'(last_wd), 32'(W_A));
    chk("rev_wm_a",   32'(last_wm), 32'o26);
    chk("rev_bm_a",   32'(bm_cnt), 3);

    // Direction change at lc = 3.
    send_word(W_B, 6'o70, 1'b1, 1'b1, 0, 3);
    @(negedge clk);
    rev = 1'b0;
    @(negedge clk);
    chk("revchg_locked", 32'(locked), 0);
    set_idle(1'b0);
    send_word(W_A, 6'o26, 1'b0, 1'b0, 0, 6);
    chk("revchg_wv", 32'(wv_cnt), 6);
    chk("revchg_wd", 32'(last_wd), 32'(W_A));

    // Reset for one cycle at lc = 3.
    send_word(W_B, 6'o70, 1'b0, 1'b0, 0, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst3_locked",    32'(locked), 0);
    chk("rst3_moving",    32'(moving), 0);
    chk("rst3_word_data", 32'(word_data), 0);
    chk("rst3_line_data", 32'(line_data), 0);
    send_word(W_B, 6'o70, 1'b0, 1'b0, 3, 3);
    chk("rst3_no_wv",   32'(wv_cnt), 6);
    chk("rst3_unlock",  32'(locked), 0);
    chk("rst3_moving2", 32'(moving), 1);
    chk("total_errs",   32'(me_cnt), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
